// File: rtl/secuenciador_detector.sv
// Controller that loads a parallel pattern and feeds it MSB-first into the serial
// sequence detector, counting the cycles in which each detector LED is lit.
module secuenciador_detector #(
   parameter int N = 8,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inicio,
   input  logic [N-1:0]  patron,
   input  logic          det_led1,
   input  logic          det_led2,
   output logic          det_entrada,
   output logic          det_reset,
   output logic          ocupado,
   output logic          listo,
   output logic [CW-1:0] cuenta_led1,
   output logic [CW-1:0] cuenta_led2
);

   localparam int IW = $clog2(N);

   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, FIN} estado_t;

   estado_t       estado;
   logic          inicio_q;
   logic          armado;
   logic          clear_q;
   logic [N-1:0]  patron_q;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_m1;
   logic          arranque;

   // A button already held at reset release must be seen low before it can start a run.
   assign arranque  = inicio & ~inicio_q & armado;
   assign idx_m1    = idx - 1'b1;
   assign det_reset = clear_q | ~reset;

   // NOTE: all state, including the registered outputs, uses non-blocking assignments so
   // every register sees the values from before the clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado      <= IDLE;
         inicio_q    <= 1'b0;
         armado      <= 1'b0;
         clear_q     <= 1'b0;
         patron_q    <= '0;
         idx         <= '0;
         cuenta_led1 <= '0;
         cuenta_led2 <= '0;
         det_entrada <= 1'b0;
         ocupado     <= 1'b0;
         listo       <= 1'b0;
      end else begin
         inicio_q <= inicio;
         armado   <= armado | ~inicio;
         case (estado)
            IDLE: begin
               if (arranque) begin
                  patron_q    <= patron;
                  cuenta_led1 <= '0;
                  cuenta_led2 <= '0;
                  estado      <= CLEAR;
                  clear_q     <= 1'b1;
                  ocupado     <= 1'b1;
               end
            end
            CLEAR: begin
               idx         <= IW'(N - 1);
               estado      <= SHIFT;
               clear_q     <= 1'b0;
               det_entrada <= patron_q[N-1];
            end
            SHIFT: begin
               // LEDs lag the serial input by one bit, so the first SHIFT cycle has nothing to count.
               if (idx != IW'(N - 1)) begin
                  cuenta_led1 <= cuenta_led1 + CW'(det_led1);
                  cuenta_led2 <= cuenta_led2 + CW'(det_led2);
               end
               if (idx == '0) begin
                  estado      <= DRAIN;
                  det_entrada <= 1'b0;
               end else begin
                  idx         <= idx_m1;
                  det_entrada <= patron_q[idx_m1];
               end
            end
            DRAIN: begin
               cuenta_led1 <= cuenta_led1 + CW'(det_led1);
               cuenta_led2 <= cuenta_led2 + CW'(det_led2);
               estado      <= FIN;
               listo       <= 1'b1;
            end
            FIN: begin
               estado  <= IDLE;
               listo   <= 1'b0;
               ocupado <= 1'b0;
            end
            default: begin
               estado      <= IDLE;
               clear_q     <= 1'b0;
               det_entrada <= 1'b0;
               listo       <= 1'b0;
               ocupado     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_secuenciador_detector.sv
// Bench for secuenciador_detector: a behavioural detector ("11" on led1, "1100" on led2),
// table-driven runs with a count scoreboard, and hand-written reset/abort/perturbation cases.
module tb_secuenciador_detector;

   localparam int N  = 8;
   localparam int CW = $clog2(N + 1);

   typedef struct {
      logic [N-1:0] patron;
      int           exp1;
      int           exp2;
      string        nombre;
   } vec_t;

   typedef struct {
      int    exp1;
      int    exp2;
      string nombre;
   } esperado_t;

   logic          clk;
   logic          reset;
   logic          inicio;
   logic [N-1:0]  patron;
   logic          det_led1;
   logic          det_led2;
   logic          det_entrada;
   logic          det_reset;
   logic          ocupado;
   logic          listo;
   logic [CW-1:0] cuenta_led1;
   logic [CW-1:0] cuenta_led2;

   int n_checks = 0;
   int n_errors = 0;
   esperado_t sb[$];
   vec_t tabla[7];

   secuenciador_detector #(.N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .inicio      (inicio),
      .patron      (patron),
      .det_led1    (det_led1),
      .det_led2    (det_led2),
      .det_entrada (det_entrada),
      .det_reset   (det_reset),
      .ocupado     (ocupado),
      .listo       (listo),
      .cuenta_led1 (cuenta_led1),
      .cuenta_led2 (cuenta_led2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Detector model: Moore outputs from the history of received bits, synchronous reset.
   logic [3:0] hist = '0;
   always @(posedge clk) begin
      if (det_reset) hist <= '0;
      else           hist <= {hist[2:0], det_entrada};
   end
   assign det_led1 = (hist[1:0] == 2'b11);
   assign det_led2 = (hist == 4'b1100);

   task automatic check(input string nombre, input int actual, input int esperado);
      n_checks++;
      if (actual !== esperado) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", nombre, actual, esperado);
      end
   endtask

   // Scoreboard: each completion pulse retires the oldest expected result.
   always @(negedge clk) begin
      if (listo === 1'b1) begin
         if (sb.size() == 0) begin
            check("listo_inesperado", 1, 0);
         end else begin
            esperado_t e;
            e = sb.pop_front();
            check({e.nombre, "_cuenta_led1"}, int'(cuenta_led1), e.exp1);
            check({e.nombre, "_cuenta_led2"}, int'(cuenta_led2), e.exp2);
         end
      end
   end

   task automatic run_case(input vec_t v, input bit perturbar);
      @(negedge clk);
      inicio = 1'b0;
      patron = v.patron;
      @(negedge clk);
      inicio = 1'b1;
      sb.push_back('{v.exp1, v.exp2, v.nombre});
      for (int k = 1; k <= N + 3; k++) begin
         @(negedge clk);
         check($sformatf("%s_ocupado_c%0d", v.nombre, k), int'(ocupado), 1);
         check($sformatf("%s_listo_c%0d", v.nombre, k), int'(listo), (k == N + 3) ? 1 : 0);
         if (k == 1)
            check($sformatf("%s_det_reset", v.nombre), int'(det_reset), 1);
         else
            check($sformatf("%s_det_reset_c%0d", v.nombre, k), int'(det_reset), 0);
         if (k >= 2 && k <= N + 1)
            check($sformatf("%s_entrada_c%0d", v.nombre, k), int'(det_entrada),
                  int'(v.patron[N+1-k]));
         else
            check($sformatf("%s_entrada_c%0d", v.nombre, k), int'(det_entrada), 0);
         if (perturbar && k == 4) begin
            inicio = 1'b0;
            patron = ~v.patron;
         end
         if (perturbar && k == 5) inicio = 1'b1;
      end
      @(negedge clk);
      check({v.nombre, "_ocupado_fin"}, int'(ocupado), 0);
      check({v.nombre, "_listo_fin"}, int'(listo), 0);
   endtask

   initial begin
      tabla[0] = '{8'b1100_1100, 2, 2, "p11001100"};
      tabla[1] = '{8'b1111_1111, 7, 0, "p11111111"};
      tabla[2] = '{8'b0000_0000, 0, 0, "p00000000"};
      tabla[3] = '{8'b1110_0110, 3, 1, "p11100110"};
      tabla[4] = '{8'b1100_0000, 1, 1, "p11000000"};
      tabla[5] = '{8'b1010_1010, 0, 0, "p10101010"};
      tabla[6] = '{8'b0011_0011, 2, 1, "p00110011"};

      reset  = 1'b0;
      inicio = 1'b1;
      patron = '0;
      repeat (3) @(negedge clk);
      check("rst_ocupado", int'(ocupado), 0);
      check("rst_listo", int'(listo), 0);
      check("rst_det_reset", int'(det_reset), 1);
      check("rst_entrada", int'(det_entrada), 0);
      check("rst_cuenta_led1", int'(cuenta_led1), 0);
      check("rst_cuenta_led2", int'(cuenta_led2), 0);

      // inicio held high across reset release must not start a run.
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_ocupado_%0d", i), int'(ocupado), 0);
         check($sformatf("post_rst_det_reset_%0d", i), int'(det_reset), 0);
      end

      foreach (tabla[i]) run_case(tabla[i], 1'b0);

      run_case('{8'b1110_0110, 3, 1, "perturbado"}, 1'b1);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("persist_ocupado_%0d", i), int'(ocupado), 0);
         check($sformatf("persist_cuenta_led1_%0d", i), int'(cuenta_led1), 3);
         check($sformatf("persist_cuenta_led2_%0d", i), int'(cuenta_led2), 1);
      end

      // Abort in the 5th SHIFT cycle; no result is expected for this run.
      @(negedge clk);
      inicio = 1'b0;
      patron = 8'b1100_1100;
      @(negedge clk);
      inicio = 1'b1;
      repeat (6) @(negedge clk);
      check("abort_ocupado_antes", int'(ocupado), 1);
      reset = 1'b0;
      #1;
      check("abort_ocupado", int'(ocupado), 0);
      check("abort_listo", int'(listo), 0);
      check("abort_det_reset", int'(det_reset), 1);
      check("abort_entrada", int'(det_entrada), 0);
      check("abort_cuenta_led1", int'(cuenta_led1), 0);
      check("abort_cuenta_led2", int'(cuenta_led2), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_sin_arranque", int'(ocupado), 0);

      run_case('{8'b1100_0000, 1, 1, "tras_abort"}, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_pendientes", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/secuenciador_detector.md
# secuenciador_detector

Controller that drives the serial sequence detector (`detector_secuencia`, ports clk/reset/entrada/led1/led2) from a parallel pattern. On a start request it latches an N-bit pattern and clears the detector. It then feeds the pattern MSB-first, one bit per clock, and counts the cycles in which each detector LED is asserted. It sits between the board-level switch/button logic and the detector, and reports the two counts plus a completion pulse to the display logic.

## Interface
- N, 8, pattern width in bits; legal range 2..15
- CW, $clog2(N+1), width of each hit counter (derived; do not override)

- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- inicio  input  1  start request, level from debounced button; a start is its rising edge
- patron  input  N  pattern to feed; sampled only on an accepted start
- det_led1  input  1  detector led1 output
- det_led2  input  1  detector led2 output
- det_entrada  output  1  serial bit to detector `entrada`
- det_reset  output  1  active-high synchronous reset to detector `reset`
- ocupado  output  1  high whenever FSM is not IDLE
- listo  output  1  one-cycle completion pulse
- cuenta_led1  output  CW  number of observed cycles with det_led1=1
- cuenta_led2  output  CW  number of observed cycles with det_led2=1

## Operation
- Registers: state, inicio_q (previous inicio), patron_q[N-1:0], idx (bit index), cuenta_led1, cuenta_led2.
- Start detect: start = inicio & ~inicio_q. Start is accepted only in IDLE. Start edges in any other state are dropped, not queued.
- FSM states and transitions:
  - IDLE: on start, latch patron into patron_q, clear both counts, go to CLEAR. Otherwise stay.
  - CLEAR: det_reset=1 for exactly this cycle. Set idx=N-1. Go to SHIFT.
  - SHIFT: det_entrada = patron_q[idx]. If idx != N-1, add det_led1 to cuenta_led1 and det_led2 to cuenta_led2, because the LEDs reflect the previous bit. If idx==0, go to DRAIN; else decrement idx.
  - DRAIN: det_entrada=0. Add det_led1/det_led2 to the counts; these reflect the last bit. Go to FIN.
  - FIN: listo=1. Go to IDLE.
- Counts hold their value from FIN until the next accepted start clears them.
- Counts never exceed N, so no saturation logic is required.
- Outputs are Moore: they are functions of state and registers only.
- det_entrada=0 in IDLE, CLEAR, DRAIN and FIN.
- det_reset = (state==CLEAR) | ~reset. The detector is therefore held in reset while the controller is in reset.
- Unused state encodings go to IDLE.

## Timing
- Reset values while reset is low: state IDLE, inicio_q 0, patron_q 0, idx 0, both counts 0, ocupado 0, listo 0, det_entrada 0, det_reset 1.
- If inicio is already high when reset releases, no start occurs. inicio must go low and then high again.
- Call the edge that samples the start edge in IDLE E. Then:
  - CLEAR occupies the cycle after E.
  - SHIFT occupies the next N cycles; pattern bit N-1 is in the first SHIFT cycle.
  - DRAIN follows, then FIN.
- ocupado is high for N+3 cycles. listo is high in the last of these cycles.
- Back-to-back runs: the earliest next accepted start is sampled in the cycle after FIN (IDLE). This requires inicio to drop and rise again.
- Reset asserted mid-run: immediate return to the reset values above, with counts cleared. No listo is produced for the aborted run.
- patron changes during a run have no effect.

## Test plan
- Reset: hold reset low with inicio=1, then release it -> ocupado stays 0 and det_reset drops to 0. No run starts until inicio toggles 0→1.
- patron=8'b1100_1100 -> det_entrada sequence 1,1,0,0,1,1,0,0. listo pulses N+3=11 cycles after the start edge is sampled. cuenta_led1=2, cuenta_led2=2.
- patron=8'b1111_1111 -> cuenta_led1=7, cuenta_led2=0. patron=8'b0000_0000 -> both counts 0. patron=8'b1110_0110 -> cuenta_led1=3, cuenta_led2=1.
- Drive a second inicio rising edge during SHIFT, and change patron mid-run -> both are ignored. Counts match the originally latched pattern, and exactly one listo pulse occurs.
- Pull reset low during the 5th SHIFT cycle -> everything returns to the reset values, with no listo. A subsequent start with patron=8'b1100_0000 gives cuenta_led1=1, cuenta_led2=1.
- Counts persist: after a run, idle 20 cycles with inicio held high -> counts unchanged and ocupado=0 throughout.
